// File: rtl/rom_fetch.sv
// rom_fetch: CPU read initiator for a pair of 8-bit synchronous program ROMs.
// A level-held request becomes a registered ROM address. The block waits out
// the ROM read latency and returns the merged {hi, lo} word. A one-word
// buffer lets a repeated read of the same word complete without the ROM.
module rom_fetch #(
    parameter int AW      = 13,
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [AW-1:0] addr,
    output logic          ack,
    output logic [15:0]   rdata,
    output logic          busy,
    output logic [AW-1:0] rom_a,
    output logic          rom_ce,
    output logic          rom_oe,
    input  logic [7:0]    rom_d_hi,
    input  logic [7:0]    rom_d_lo
);

    // The counter needs to hold LATENCY. Keep at least one bit when LATENCY is 0.
    localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          buf_valid;
    logic [AW-1:0] buf_addr;
    logic [15:0]   buf_data;
    logic          hit;

    // Buffer hit: the requested word matches the last word fetched from the ROM.
    assign hit = buf_valid && (addr == buf_addr);

    // Control FSM: handles the request, the ROM wait, the ack handshake and the strobe gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ack       <= 1'b0;
            rdata     <= 16'h0000;
            busy      <= 1'b0;
            rom_a     <= '0;
            rom_ce    <= 1'b0;
            rom_oe    <= 1'b0;
            buf_valid <= 1'b0;
            buf_addr  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        busy <= 1'b1;
                        if (hit) begin
                            rdata <= buf_data;
                            ack   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            rom_a  <= addr;
                            rom_ce <= 1'b1;
                            rom_oe <= 1'b1;
                            cnt    <= CW'(LATENCY);
                            state  <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        // ROM data is valid now. Refill the buffer even if the CPU has left.
                        rdata     <= {rom_d_hi, rom_d_lo};
                        buf_addr  <= rom_a;
                        buf_valid <= 1'b1;
                        rom_ce    <= 1'b0;
                        rom_oe    <= 1'b0;
                        if (req) begin
                            ack   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    if (!req) begin
                        ack   <= 1'b0;
                        state <= S_DROP;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Buffer data register. It is used only when buf_valid is set, so it has no reset.
    always_ff @(posedge clk) begin
        if (state == S_FETCH && cnt == '0) begin
            buf_data <= {rom_d_hi, rom_d_lo};
        end
    end

endmodule

// File: tb/tb_rom_fetch.sv
// Testbench for rom_fetch. It models a registered-output ROM pair and checks the
// DUT against a behavioural reference of the one-word buffer and the read timing.
module tb_rom_fetch;

    localparam int AW  = 13;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic [AW-1:0] addr;
    logic          ack;
    logic [15:0]   rdata;
    logic          busy;
    logic [AW-1:0] rom_a;
    logic          rom_ce;
    logic          rom_oe;
    logic [7:0]    rom_d_hi;
    logic [7:0]    rom_d_lo;

    logic [7:0] mem_hi [0:(1<<AW)-1];
    logic [7:0] mem_lo [0:(1<<AW)-1];

    int tests = 0;
    int fails = 0;

    // Reference state: what the last-word buffer should hold
    bit            m_valid;
    logic [AW-1:0] m_addr;

    rom_fetch #(.AW(AW), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .addr(addr),
        .ack(ack), .rdata(rdata), .busy(busy),
        .rom_a(rom_a), .rom_ce(rom_ce), .rom_oe(rom_oe),
        .rom_d_hi(rom_d_hi), .rom_d_lo(rom_d_lo)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with registered output: data for rom_a appears one clock later
    always @(posedge clk) begin
        rom_d_hi <= mem_hi[rom_a];
        rom_d_lo <= mem_lo[rom_a];
    end

    function automatic logic [15:0] word_of(input logic [AW-1:0] a);
        return {mem_hi[a], mem_lo[a]};
    endfunction

    // Issue a read and keep req high. The model predicts hit or miss, the latency and the data.
    task automatic do_read(input logic [AW-1:0] a, input string name);
        bit  exp_hit;
        int  exp_lat;
        int  n;
        bit  got;
        bit  saw_ce;
        exp_hit = m_valid && (m_addr == a);
        exp_lat = exp_hit ? 1 : LAT + 2;
        @(negedge clk);
        req  = 1'b1;
        addr = a;
        n = 0; got = 0; saw_ce = 0;
        while (n < 20 && !got) begin
            @(posedge clk); #1;
            n++;
            if (rom_ce) saw_ce = 1;
            if (ack) got = 1;
        end
        tests++;
        if (!got || n !== exp_lat) begin
            fails++;
            $display("FAIL %s latency: got %0d clocks (ack=%0b), want %0d", name, n, got, exp_lat);
        end
        tests++;
        if (rdata !== word_of(a)) begin
            fails++;
            $display("FAIL %s rdata: got %h, want %h", name, rdata, word_of(a));
        end
        tests++;
        if (exp_hit ? (saw_ce !== 1'b0) : (rom_a !== a || rom_ce !== 1'b0 || rom_oe !== 1'b0)) begin
            fails++;
            $display("FAIL %s rom: saw_ce=%0b rom_a=%h ce=%0b oe=%0b, want hit=%0b addr=%h ce=0 oe=0",
                     name, saw_ce, rom_a, rom_ce, rom_oe, exp_hit, a);
        end
        m_valid = 1;
        m_addr  = a;
    endtask

    // Drop req. ack falls at the next edge, then one DROP clock, then busy clears.
    task automatic do_release(input string name);
        int n;
        @(negedge clk);
        req = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (ack !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s release: ack=%0b busy=%0b, want ack=0 busy=1", name, ack, busy);
        end
        n = 0;
        while (busy && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (busy !== 1'b0 || n !== 1) begin
            fails++;
            $display("FAIL %s drop gap: busy=%0b after %0d clocks, want 0 after 1", name, busy, n);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        tests++;
        if (ack !== 1'b0 || busy !== 1'b0 || rom_ce !== 1'b0 || rom_oe !== 1'b0 ||
            rdata !== 16'h0000 || rom_a !== '0) begin
            fails++;
            $display("FAIL %s: ack=%0b busy=%0b ce=%0b oe=%0b rdata=%h rom_a=%h, want all 0",
                     name, ack, busy, rom_ce, rom_oe, rdata, rom_a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        reset = 1'b0;
        m_valid = 0;
        m_addr  = '0;
    endtask

    task automatic test_miss_then_hit();
        mem_hi[13'h0010] = 8'hA5;
        mem_lo[13'h0010] = 8'h3C;
        do_read(13'h0010, "first_miss");
        do_release("first_miss");
        do_read(13'h0010, "repeat_hit");
        do_release("repeat_hit");
    endtask

    task automatic test_wrap();
        do_read(13'h1FFF, "all_ones");
        do_release("all_ones");
        do_read(13'h0000, "zero_addr");
        do_release("zero_addr");
        do_read(13'h0000, "zero_rehit");
        do_release("zero_rehit");
    endtask

    task automatic test_abort();
        bit saw_ack;
        int n;
        @(negedge clk);
        req = 1'b1; addr = 13'h0123;
        @(posedge clk); #1;
        @(negedge clk);
        req = 1'b0;
        saw_ack = 0;
        n = 0;
        while (busy && n < 10) begin
            @(posedge clk); #1;
            n++;
            if (ack) saw_ack = 1;
        end
        tests++;
        if (saw_ack !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort: saw_ack=%0b busy=%0b, want 0 0", saw_ack, busy);
        end
        m_valid = 1;
        m_addr  = 13'h0123;
        do_read(13'h0123, "abort_rehit");
        do_release("abort_rehit");
    endtask

    task automatic test_addr_change_while_busy();
        logic [15:0] held;
        do_read(13'h0321, "hold_read");
        held = rdata;
        @(negedge clk);
        addr = 13'h0456;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (rdata !== held || ack !== 1'b1) begin
            fails++;
            $display("FAIL hold_frozen: rdata=%h ack=%0b, want %h 1", rdata, ack, held);
        end
        do_release("hold_read");
        do_read(13'h0456, "new_addr_miss");
        do_release("new_addr_miss");
    endtask

    task automatic test_reset_midway();
        // Reset during FETCH
        @(negedge clk);
        req = 1'b1; addr = 13'h0777;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("reset_in_fetch");
        @(negedge clk);
        reset = 1'b0; req = 1'b0;
        m_valid = 0;
        do_read(13'h0777, "after_fetch_reset");
        // Reset during DONE
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("reset_in_done");
        @(negedge clk);
        reset = 1'b0; req = 1'b0;
        m_valid = 0;
        do_read(13'h0777, "after_done_reset");
        do_release("after_done_reset");
    endtask

    task automatic test_random();
        logic [AW-1:0] pool [4];
        logic [AW-1:0] a;
        for (int i = 0; i < 4; i++) pool[i] = AW'($urandom);
        pool[3] = '1;
        for (int i = 0; i < 40; i++) begin
            a = pool[$urandom_range(0, 3)];
            do_read(a, "random");
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_release("random");
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem_hi[i] = 8'($urandom);
            mem_lo[i] = 8'($urandom);
        end
        test_reset();
        test_miss_then_hit();
        test_wrap();
        test_abort();
        test_addr_change_while_busy();
        test_reset_midway();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
